serial_parity_unit: RTL and testbench

Bit-serial parity generator/checker, downstream of the gate-level xor stage; its per-bit accumulator update is built from the existing my_xor cell. It accumulates the XOR of a FRAME_LEN-bit serial frame. In generate mode it outputs the frame parity bit. In check mode it also consumes one trailing received parity bit and flags a mismatch. It feeds serial-link framing and test-bench checking logic.

---
 rtl/parity_pkg.sv | 13 +
 rtl/my_xor.sv | 10 +
 rtl/serial_parity_unit.sv | 116 +++++++++++
 tb/tb_serial_parity_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// Shared definitions for the bit-serial parity generator/checker.
package parity_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_PAR  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int DEFAULT_FRAME_LEN = 8;

endpackage : parity_pkg

// File: rtl/my_xor.sv
// Two-input XOR cell from the gate-level xor stage; used as the accumulator update.
module my_xor (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = a ^ b;

endmodule : my_xor

// File: rtl/serial_parity_unit.sv
// Bit-serial parity generator/checker: accumulates the XOR of a FRAME_LEN-bit frame,
// reports its parity and, in check mode, compares it with a trailing received parity bit.
module serial_parity_unit
  import parity_pkg::*;
#(
  parameter int FRAME_LEN = DEFAULT_FRAME_LEN,
  parameter int ODD       = 0,
  parameter int CW        = $clog2(FRAME_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          check_mode,
  input  logic          din,
  input  logic          din_valid,
  output logic          busy,
  output logic          done,
  output logic          parity,
  output logic          err,
  output logic [CW-1:0] bit_cnt
);

  localparam logic          ODD_BIT  = 1'(ODD);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

  state_e        state_q, state_d;
  logic          acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mode_q, mode_d;
  logic          parity_q, parity_d;
  logic          err_q, err_d;
  logic          acc_nxt;

  my_xor u_acc_xor (
    .a (acc_q),
    .b (din),
    .y (acc_nxt)
  );

  always_comb begin
    // NOTE: every _d gets a hold default before the case so no path leaves a signal unassigned, which would infer a latch.
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    parity_d = parity_q;
    err_d    = err_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_DATA;
          acc_d    = 1'b0;
          cnt_d    = '0;
          mode_d   = check_mode;
          parity_d = 1'b0;
          err_d    = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_DATA: begin
        if (din_valid) begin
          acc_d = acc_nxt;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_IDX) begin
            if (mode_q) begin
              state_d = ST_PAR;
            end else begin
              state_d  = ST_DONE;
              parity_d = acc_nxt ^ ODD_BIT;
            end
          end
        end
      end

      // acc holds the data parity here; din is the received parity bit.
      ST_PAR: begin
        if (din_valid) begin
          state_d  = ST_DONE;
          err_d    = (acc_nxt != ODD_BIT);
          parity_d = acc_q ^ ODD_BIT;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values of its peers.
    if (rst) begin
      state_q  <= ST_IDLE;
      acc_q    <= 1'b0;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      parity_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      parity_q <= parity_d;
      err_q    <= err_d;
    end
  end

  assign busy    = (state_q == ST_DATA) || (state_q == ST_PAR);
  assign done    = (state_q == ST_DONE);
  assign parity  = parity_q;
  assign err     = err_q;
  assign bit_cnt = cnt_q;

endmodule : serial_parity_unit

// File: tb/tb_serial_parity_unit.sv
// Directed bench: an even-parity and an odd-parity instance share one stimulus stream.
module tb_serial_parity_unit;

  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst, start, check_mode, din, din_valid;

  logic          busy0, done0, parity0, err0;
  logic [CW-1:0] cnt0;
  logic          busy1, done1, parity1, err1;
  logic [CW-1:0] cnt1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_parity_unit #(.FRAME_LEN(8), .ODD(0)) u_even (
    .clk(clk), .rst(rst), .start(start), .check_mode(check_mode),
    .din(din), .din_valid(din_valid),
    .busy(busy0), .done(done0), .parity(parity0), .err(err0), .bit_cnt(cnt0)
  );

  serial_parity_unit #(.FRAME_LEN(8), .ODD(1)) u_odd (
    .clk(clk), .rst(rst), .start(start), .check_mode(check_mode),
    .din(din), .din_valid(din_valid),
    .busy(busy1), .done(done1), .parity(parity1), .err(err1), .bit_cnt(cnt1)
  );

  // Advance one clock; outputs are then observed 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_frame(input logic mode);
    start      = 1'b1;
    check_mode = mode;
    din_valid  = 1'b0;
    step();
    start      = 1'b0;
    check_mode = 1'b0;
  endtask

  // Sends data[lo] .. data[hi-1] back to back, first bit first.
  task automatic send_bits(input logic [7:0] data, input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      din       = data[i];
      din_valid = 1'b1;
      step();
    end
    din_valid = 1'b0;
    din       = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    din       = b;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    din       = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; check_mode = 1'b0; din = 1'b0; din_valid = 1'b0;
    step(); step();
    rst = 1'b0;
    checks++;
    if ({busy0, done0, parity0, err0, cnt0} !== 8'h00) begin
      errors++;
      $display("FAIL reset_even: got busy=%b done=%b par=%b err=%b cnt=%0d, want all 0",
               busy0, done0, parity0, err0, cnt0);
    end
    checks++;
    if ({busy1, done1, parity1, err1, cnt1} !== 8'h00) begin
      errors++;
      $display("FAIL reset_odd: got busy=%b done=%b par=%b err=%b cnt=%0d, want all 0",
               busy1, done1, parity1, err1, cnt1);
    end
    send_bit(1'b1);
    checks++;
    if (busy0 !== 1'b0 || cnt0 !== 4'd0) begin
      errors++;
      $display("FAIL idle_valid_ignored: got busy=%b cnt=%0d, want busy=0 cnt=0", busy0, cnt0);
    end
  endtask

  task automatic test_generate();
    begin_frame(1'b0);
    send_bits(8'b0000_1101, 0, 7);
    checks++;
    if (busy0 !== 1'b1 || done0 !== 1'b0 || cnt0 !== 4'd7) begin
      errors++;
      $display("FAIL gen_before_last: got busy=%b done=%b cnt=%0d, want 1 0 7", busy0, done0, cnt0);
    end
    send_bits(8'b0000_1101, 7, 8);
    checks++;
    if (done0 !== 1'b1 || busy0 !== 1'b0 || parity0 !== 1'b1 || err0 !== 1'b0 || cnt0 !== 4'd8) begin
      errors++;
      $display("FAIL gen_even_done: got done=%b busy=%b par=%b err=%b cnt=%0d, want 1 0 1 0 8",
               done0, busy0, parity0, err0, cnt0);
    end
    checks++;
    if (done1 !== 1'b1 || parity1 !== 1'b0) begin
      errors++;
      $display("FAIL gen_odd_done: got done=%b par=%b, want 1 0", done1, parity1);
    end
    step();
    checks++;
    if (done0 !== 1'b0 || parity0 !== 1'b1 || parity1 !== 1'b0) begin
      errors++;
      $display("FAIL gen_pulse_hold: got done=%b par0=%b par1=%b, want 0 1 0", done0, parity0, parity1);
    end
  endtask

  task automatic test_check();
    begin_frame(1'b1);
    send_bits(8'b0000_0111, 0, 8);
    checks++;
    if (busy0 !== 1'b1 || done0 !== 1'b0 || cnt0 !== 4'd8) begin
      errors++;
      $display("FAIL chk_in_par: got busy=%b done=%b cnt=%0d, want 1 0 8", busy0, done0, cnt0);
    end
    send_bit(1'b1);
    checks++;
    if (done0 !== 1'b1 || err0 !== 1'b0 || parity0 !== 1'b1 || cnt0 !== 4'd8) begin
      errors++;
      $display("FAIL chk_match_even: got done=%b err=%b par=%b cnt=%0d, want 1 0 1 8",
               done0, err0, parity0, cnt0);
    end
    checks++;
    if (err1 !== 1'b1 || parity1 !== 1'b0) begin
      errors++;
      $display("FAIL chk_match_odd: got err=%b par=%b, want 1 0", err1, parity1);
    end
    step();
    begin_frame(1'b1);
    send_bits(8'b0000_0111, 0, 8);
    send_bit(1'b0);
    checks++;
    if (done0 !== 1'b1 || err0 !== 1'b1 || err1 !== 1'b0) begin
      errors++;
      $display("FAIL chk_mismatch: got done=%b err0=%b err1=%b, want 1 1 0", done0, err0, err1);
    end
    step();
    checks++;
    if (err0 !== 1'b1 || done0 !== 1'b0) begin
      errors++;
      $display("FAIL chk_err_hold: got err=%b done=%b, want 1 0", err0, done0);
    end
  endtask

  task automatic test_stall();
    begin_frame(1'b0);
    send_bits(8'b0000_1101, 0, 4);
    for (int i = 0; i < 3; i++) begin
      din = 1'b1;
      step();
      checks++;
      if (cnt0 !== 4'd4 || busy0 !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold_%0d: got cnt=%0d busy=%b, want 4 1", i, cnt0, busy0);
      end
    end
    send_bits(8'b0000_1101, 4, 8);
    checks++;
    if (done0 !== 1'b1 || parity0 !== 1'b1 || parity1 !== 1'b0) begin
      errors++;
      $display("FAIL stall_parity: got done=%b par0=%b par1=%b, want 1 1 0", done0, parity0, parity1);
    end
    step();
  endtask

  task automatic test_mid_reset();
    begin_frame(1'b0);
    send_bits(8'b1111_1111, 0, 5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (busy0 !== 1'b0 || cnt0 !== 4'd0 || parity0 !== 1'b0 || done0 !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state: got busy=%b cnt=%0d par=%b done=%b, want 0 0 0 0",
               busy0, cnt0, parity0, done0);
    end
    step();
    checks++;
    if (done0 !== 1'b0 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL midrst_no_done: got done=%b busy=%b, want 0 0", done0, busy0);
    end
    begin_frame(1'b0);
    send_bits(8'b1111_1111, 0, 8);
    checks++;
    if (done0 !== 1'b1 || parity0 !== 1'b0 || parity1 !== 1'b1) begin
      errors++;
      $display("FAIL ones_frame: got done=%b par0=%b par1=%b, want 1 0 1", done0, parity0, parity1);
    end
    step();
    begin_frame(1'b0);
    send_bits(8'b0000_0000, 0, 8);
    checks++;
    if (done0 !== 1'b1 || parity0 !== 1'b0 || parity1 !== 1'b1) begin
      errors++;
      $display("FAIL zero_frame: got done=%b par0=%b par1=%b, want 1 0 1", done0, parity0, parity1);
    end
    step();
  endtask

  task automatic test_back_to_back();
    begin_frame(1'b0);
    send_bits(8'b0000_1101, 0, 3);
    start = 1'b1; check_mode = 1'b1;
    send_bits(8'b0000_1101, 3, 4);
    start = 1'b0; check_mode = 1'b0;
    checks++;
    if (cnt0 !== 4'd4 || busy0 !== 1'b1) begin
      errors++;
      $display("FAIL start_while_busy: got cnt=%0d busy=%b, want 4 1", cnt0, busy0);
    end
    send_bits(8'b0000_1101, 4, 8);
    checks++;
    if (done0 !== 1'b1 || parity0 !== 1'b1) begin
      errors++;
      $display("FAIL mode_latched: got done=%b par=%b, want 1 1", done0, parity0);
    end
    // Restart from DONE with a valid bit that must not be consumed.
    start = 1'b1; din = 1'b1; din_valid = 1'b1;
    step();
    start = 1'b0; din_valid = 1'b0; din = 1'b0;
    checks++;
    if (busy0 !== 1'b1 || done0 !== 1'b0 || cnt0 !== 4'd0 || parity0 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_restart: got busy=%b done=%b cnt=%0d par=%b, want 1 0 0 0",
               busy0, done0, cnt0, parity0);
    end
    send_bits(8'b0000_0011, 0, 1);
    checks++;
    if (cnt0 !== 4'd1) begin
      errors++;
      $display("FAIL b2b_first_bit: got cnt=%0d, want 1", cnt0);
    end
    send_bits(8'b0000_0011, 1, 8);
    checks++;
    if (done0 !== 1'b1 || parity0 !== 1'b0 || parity1 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_parity: got done=%b par0=%b par1=%b, want 1 0 1", done0, parity0, parity1);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_generate();
    test_check();
    test_stall();
    test_mid_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_serial_parity_unit
